alu: RTL and testbench

//  8-bit combinational-datapath ALU with registered outputs. Computes one of eight

---
 rtl/alu.sv | 114 +++++++++++
 tb/tb_alu.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8-bit ALU with registered result and N/C/V/Z flags, one-cycle latency.
// Define ALU_SATURATE_EN to make ADD/SUB saturate in the signed domain on overflow.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] Select,
  output logic [7:0] Result,
  output logic       N,
  output logic       C,
  output logic       V,
  output logic       Z
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } op_e;

  op_e        op;
  logic [8:0] sum;
  logic [8:0] diff;
  logic       add_ovf;
  logic       sub_ovf;

  logic [7:0] result_d, result_q;
  logic       n_d, n_q;
  logic       c_d, c_q;
  logic       v_d, v_q;
  logic       z_d, z_q;

  assign op   = op_e'(Select);
  assign sum  = {1'b0, A} + {1'b0, B};
  // Bit 8 of the 9-bit difference is the unsigned borrow (A < B).
  assign diff = {1'b0, A} - {1'b0, B};

  assign add_ovf = (A[7] == B[7]) && (sum[7] != A[7]);
  assign sub_ovf = (A[7] != B[7]) && (diff[7] != A[7]);

  always_comb begin
    result_d = 8'h00;
    c_d      = 1'b0;
    v_d      = 1'b0;
    unique case (op)
      OpAdd: begin
        result_d = sum[7:0];
        c_d      = sum[8];
        v_d      = add_ovf;
`ifdef ALU_SATURATE_EN
        // On overflow the true result carries the sign of A.
        if (add_ovf) result_d = A[7] ? 8'h80 : 8'h7F;
`endif
      end
      OpSub: begin
        result_d = diff[7:0];
        c_d      = diff[8];
        v_d      = sub_ovf;
`ifdef ALU_SATURATE_EN
        if (sub_ovf) result_d = A[7] ? 8'h80 : 8'h7F;
`endif
      end
      OpAnd: result_d = A & B;
      OpOr:  result_d = A | B;
      OpXor: result_d = A ^ B;
      OpNot: result_d = ~A;
      OpShl: begin
        result_d = {A[6:0], 1'b0};
        c_d      = A[7];
        v_d      = A[7] ^ A[6];
      end
      OpShr: begin
        result_d = {1'b0, A[7:1]};
        c_d      = A[0];
      end
      default: begin
        result_d = 8'h00;
        c_d      = 1'b0;
        v_d      = 1'b0;
      end
    endcase
    n_d = result_d[7];
    z_d = (result_d == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 8'h00;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b1;
    end else begin
      result_q <= result_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  assign Result = result_q;
  assign N      = n_q;
  assign C      = c_q;
  assign V      = v_q;
  assign Z      = z_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues hand-computed expectations, monitor checks them.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] Select;
  logic [7:0] Result;
  logic       N;
  logic       C;
  logic       V;
  logic       Z;

  typedef struct {
    logic [7:0] r;
    logic       n;
    logic       c;
    logic       v;
    logic       z;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011,
                         XOR = 3'b100, NOT = 3'b101, SHL = 3'b110, SHR = 3'b111;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Select (Select),
    .Result (Result),
    .N      (N),
    .C      (C),
    .V      (V),
    .Z      (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation just after an edge; its result is due after the following edge.
  task automatic issue(input logic r, input logic [2:0] sel, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic en,
                       input logic ec, input logic ev, input logic ez, input string name);
    exp_t e;
    @(posedge clk);
    #2;
    rst    = r;
    Select = sel;
    A      = a;
    B      = b;
    e.r = er; e.n = en; e.c = ec; e.v = ev; e.z = ez; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic chk1(input string name, input string fld, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s.%s: got %b, expected %b", name, fld, act, req);
    end
  endtask

  // Monitor: the DUT presents a new output every cycle, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (Result !== e.r) begin
          n_fails++;
          $display("FAIL %s.Result: got %h, expected %h", e.name, Result, e.r);
        end
        chk1(e.name, "N", N, e.n);
        chk1(e.name, "C", C, e.c);
        chk1(e.name, "V", V, e.v);
        chk1(e.name, "Z", Z, e.z);
      end
    end
  end

  initial begin
    rst = 1'b1; A = 8'h00; B = 8'h00; Select = 3'b000;

    // Reset with nonzero inputs
    issue(1, ADD, 8'hFF, 8'h01, 8'h00, 0, 0, 0, 1, "reset");
    issue(1, SUB, 8'h05, 8'h07, 8'h00, 0, 0, 0, 1, "reset_hold");
`ifdef ALU_SATURATE_EN
    issue(0, ADD, 8'h7F, 8'h01, 8'h7F, 0, 0, 1, 0, "add_ovf_pos");
    issue(0, ADD, 8'h80, 8'h80, 8'h80, 1, 1, 1, 0, "add_ovf_neg");
    issue(0, SUB, 8'h7F, 8'hFF, 8'h7F, 0, 1, 1, 0, "sub_ovf_pos");
`else
    issue(0, ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 1, 0, "add_ovf_pos");
    issue(0, ADD, 8'h80, 8'h80, 8'h00, 0, 1, 1, 1, "add_ovf_neg");
    issue(0, SUB, 8'h7F, 8'hFF, 8'h80, 1, 1, 1, 0, "sub_ovf_pos");
`endif
    issue(0, ADD, 8'hFF, 8'h01, 8'h00, 0, 1, 0, 1, "add_carry");
    issue(0, SUB, 8'h05, 8'h07, 8'hFE, 1, 1, 0, 0, "sub_borrow");
    issue(0, AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, "and");
    issue(0, OR,  8'hF0, 8'h3C, 8'hFC, 1, 0, 0, 0, "or");
    issue(0, XOR, 8'hAA, 8'hAA, 8'h00, 0, 0, 0, 1, "xor_zero");
    issue(0, NOT, 8'h0F, 8'h55, 8'hF0, 1, 0, 0, 0, "not");
    issue(0, SHL, 8'hC0, 8'hFF, 8'h80, 1, 1, 0, 0, "shl");
    issue(0, SHR, 8'h01, 8'hFF, 8'h00, 0, 1, 0, 1, "shr");

    // Back-to-back sweep of all opcodes
    issue(0, ADD, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, "b2b_add");
`ifdef ALU_SATURATE_EN
    issue(0, SUB, 8'h80, 8'h01, 8'h80, 1, 0, 1, 0, "b2b_sub");
`else
    issue(0, SUB, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 0, "b2b_sub");
`endif
    issue(0, AND, 8'hFF, 8'h0F, 8'h0F, 0, 0, 0, 0, "b2b_and");
    issue(0, OR,  8'h00, 8'h00, 8'h00, 0, 0, 0, 1, "b2b_or");
    issue(0, XOR, 8'h5A, 8'h0F, 8'h55, 0, 0, 0, 0, "b2b_xor");
    issue(0, NOT, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 1, "b2b_not");
    issue(0, SHL, 8'h40, 8'h00, 8'h80, 1, 0, 1, 0, "b2b_shl");
    issue(0, SHR, 8'h81, 8'h00, 8'h40, 0, 1, 0, 0, "b2b_shr");

    // Mid-stream reset, then resume
    issue(1, ADD, 8'hFF, 8'h01, 8'h00, 0, 0, 0, 1, "mid_reset");
    issue(0, SUB, 8'h00, 8'h01, 8'hFF, 1, 1, 0, 0, "post_reset_sub");
    issue(0, SHL, 8'h81, 8'h00, 8'h02, 0, 1, 1, 0, "post_reset_shl");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
